// File: rtl/knight_rider_monitor.sv
// knight_rider_monitor
//   Receive-side checker for the knight_rider LED scanner. Integrates per-LED
//   on-time over windows of 2**WIN_W clocks, which strips brightness PWM. At
//   each window end it selects the brightest LED as the head and checks that
//   the head sweeps legally, one position per window, reversing only at the
//   end LEDs.
//
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   leds         scanner LED outputs, sampled every clk
//   head_valid   head_pos holds a tracked position
//   head_pos     index of current head LED
//   dir          0 = moving toward higher index, 1 = toward lower
//   step_pulse   1-clk pulse, head moved by one position
//   bounce_pulse 1-clk pulse, legal reversal at an end LED
//   sweep_count  legal bounces since reset, saturating
//   err_sticky   set on first error, cleared only by rst
//   err_code     first error: 0 none, 1 JUMP, 2 REVERSAL, 3 DARK
//
//   state  | meaning
//   S_IDLE | no head tracked yet (after reset or a dark frame)
//   S_TRACK| head_pos valid, every new frame is checked against it
module knight_rider_monitor #(
   parameter int OUT_WIDTH = 8,
   parameter int WIN_W     = 8,
   localparam int PW       = $clog2(OUT_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OUT_WIDTH-1:0] leds,
   output logic                 head_valid,
   output logic [PW-1:0]        head_pos,
   output logic                 dir,
   output logic                 step_pulse,
   output logic                 bounce_pulse,
   output logic [15:0]          sweep_count,
   output logic                 err_sticky,
   output logic [1:0]           err_code
);

   typedef enum logic {S_IDLE, S_TRACK} state_t;

   localparam logic [WIN_W-1:0] WIN_MAX = '1;
   localparam logic [PW-1:0]    POS_MAX = PW'(OUT_WIDTH - 1);
   localparam logic [1:0]       E_JUMP  = 2'd1;
   localparam logic [1:0]       E_REV   = 2'd2;
   localparam logic [1:0]       E_DARK  = 2'd3;

   state_t             state_q, state_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [WIN_W:0]     duty_q [OUT_WIDTH];
   logic [WIN_W:0]     duty_d [OUT_WIDTH];
   logic               head_valid_q, head_valid_d;
   logic [PW-1:0]      head_pos_q, head_pos_d;
   logic               dir_q, dir_d;
   logic               dir_known_q, dir_known_d;
   logic               step_q, step_d;
   logic               bounce_q, bounce_d;
   logic [15:0]        sweep_q, sweep_d;
   logic               err_sticky_q, err_sticky_d;
   logic [1:0]         err_code_q, err_code_d;

   logic [WIN_W:0]     frame [OUT_WIDTH];
   logic [WIN_W:0]     head_duty;
   logic [PW-1:0]      head_n;
   logic               win_end;
   logic               dark;
   logic signed [PW:0] diff;
   logic               adj;
   logic               mv_down;
   logic               err_hit;
   logic [1:0]         err_val;

   assign win_end = (win_cnt_q == WIN_MAX);

   // The frame includes the current sample, so the window-end cycle counts.
   // Strict '>' keeps the lowest index on ties.
   always_comb begin
      head_duty = '0;
      head_n    = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         frame[i]  = duty_q[i] + (WIN_W+1)'(leds[i]);
         duty_d[i] = win_end ? '0 : frame[i];
         if (frame[i] > head_duty) begin
            head_duty = frame[i];
            head_n    = PW'(i);
         end
      end
      dark    = (head_duty == '0);
      diff    = $signed({1'b0, head_n}) - $signed({1'b0, head_pos_q});
      adj     = (diff == (PW+1)'(1)) || (diff == '1);
      mv_down = diff[PW];
   end

   always_comb begin
      state_d      = state_q;
      win_cnt_d    = win_cnt_q + 1'b1;
      head_valid_d = head_valid_q;
      head_pos_d   = head_pos_q;
      dir_d        = dir_q;
      dir_known_d  = dir_known_q;
      step_d       = 1'b0;
      bounce_d     = 1'b0;
      sweep_d      = sweep_q;
      err_sticky_d = err_sticky_q;
      err_code_d   = err_code_q;
      err_hit      = 1'b0;
      err_val      = 2'd0;

      if (win_end) begin
         head_pos_d = head_n;
         case (state_q)
            S_IDLE: begin
               if (!dark) begin
                  head_valid_d = 1'b1;
                  dir_known_d  = 1'b0;
                  state_d      = S_TRACK;
               end
            end
            S_TRACK: begin
               if (dark) begin
                  err_hit      = 1'b1;
                  err_val      = E_DARK;
                  head_valid_d = 1'b0;
                  state_d      = S_IDLE;
               end else if (diff == '0) begin
                  step_d = 1'b0;
               end else if (adj) begin
                  step_d = 1'b1;
                  if (!dir_known_q) begin
                     dir_d       = mv_down;
                     dir_known_d = 1'b1;
                  end else if (mv_down != dir_q) begin
                     dir_d = mv_down;
                     if ((head_pos_q == POS_MAX && !dir_q) || (head_pos_q == '0 && dir_q)) begin
                        bounce_d = 1'b1;
                        if (sweep_q != 16'hFFFF) sweep_d = sweep_q + 16'd1;
                     end else begin
                        err_hit = 1'b1;
                        err_val = E_REV;
                     end
                  end
               end else begin
                  err_hit     = 1'b1;
                  err_val     = E_JUMP;
                  dir_known_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (err_hit && !err_sticky_q) begin
         err_sticky_d = 1'b1;
         err_code_d   = err_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         win_cnt_q    <= '0;
         duty_q       <= '{default: '0};
         head_valid_q <= 1'b0;
         head_pos_q   <= '0;
         dir_q        <= 1'b0;
         dir_known_q  <= 1'b0;
         step_q       <= 1'b0;
         bounce_q     <= 1'b0;
         sweep_q      <= '0;
         err_sticky_q <= 1'b0;
         err_code_q   <= '0;
      end else begin
         state_q      <= state_d;
         win_cnt_q    <= win_cnt_d;
         duty_q       <= duty_d;
         head_valid_q <= head_valid_d;
         head_pos_q   <= head_pos_d;
         dir_q        <= dir_d;
         dir_known_q  <= dir_known_d;
         step_q       <= step_d;
         bounce_q     <= bounce_d;
         sweep_q      <= sweep_d;
         err_sticky_q <= err_sticky_d;
         err_code_q   <= err_code_d;
      end
   end

   assign head_valid   = head_valid_q;
   assign head_pos     = head_pos_q;
   assign dir          = dir_q;
   assign step_pulse   = step_q;
   assign bounce_pulse = bounce_q;
   assign sweep_count  = sweep_q;
   assign err_sticky   = err_sticky_q;
   assign err_code     = err_code_q;

endmodule

// File: tb/tb_knight_rider_monitor.sv
// Testbench for knight_rider_monitor: windows are described as per-LED on-time
// counts, a reference model applies the sweep rules to each window, and the
// expected outputs are queued with the cycle at which they must appear.
module tb_knight_rider_monitor;

   localparam int NL  = 8;
   localparam int WIN = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  leds = '0;
   logic        head_valid;
   logic [2:0]  head_pos;
   logic        dir;
   logic        step_pulse;
   logic        bounce_pulse;
   logic [15:0] sweep_count;
   logic        err_sticky;
   logic [1:0]  err_code;

   knight_rider_monitor #(.OUT_WIDTH(8), .WIN_W(8)) dut (
      .clk(clk), .rst(rst), .leds(leds),
      .head_valid(head_valid), .head_pos(head_pos), .dir(dir),
      .step_pulse(step_pulse), .bounce_pulse(bounce_pulse),
      .sweep_count(sweep_count), .err_sticky(err_sticky), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic        hv;
      logic [2:0]  hp;
      logic        dr;
      logic        sp;
      logic        bp;
      logic [15:0] sw;
      logic        es;
      logic [1:0]  ec;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   int win_duty [NL];
   int win_off  [NL];

   // reference model state
   bit m_track, m_valid, m_dir, m_dk, m_err;
   int m_h, m_sweep, m_code;
   bit m_sp, m_bp;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // monitor: samples 1 time unit after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("missed_sample", cyc, e.cyc);
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("head_valid",   32'(head_valid),   32'(e.hv));
            check("head_pos",     32'(head_pos),     32'(e.hp));
            check("dir",          32'(dir),          32'(e.dr));
            check("step_pulse",   32'(step_pulse),   32'(e.sp));
            check("bounce_pulse", 32'(bounce_pulse), 32'(e.bp));
            check("sweep_count",  32'(sweep_count),  32'(e.sw));
            check("err_sticky",   32'(err_sticky),   32'(e.es));
            check("err_code",     32'(err_code),     32'(e.ec));
         end else begin
            check("pulse_quiet", 32'({step_pulse, bounce_pulse}), 32'd0);
         end
      end
   end

   function automatic exp_t snap(input int unsigned at);
      exp_t e;
      e.cyc = at;
      e.hv  = m_valid;
      e.hp  = 3'(m_h);
      e.dr  = m_dir;
      e.sp  = m_sp;
      e.bp  = m_bp;
      e.sw  = 16'(m_sweep);
      e.es  = m_err;
      e.ec  = 2'(m_code);
      return e;
   endfunction

   task automatic model_reset();
      m_track = 0; m_valid = 0; m_dir = 0; m_dk = 0; m_err = 0;
      m_h = 0; m_sweep = 0; m_code = 0; m_sp = 0; m_bp = 0;
   endtask

   task automatic model_err(input int c);
      if (!m_err) begin
         m_err  = 1;
         m_code = c;
      end
   endtask

   // one window of the sweep rules, computed from on-time counts
   task automatic model_window();
      int n, best, delta;
      bit down;
      n = 0; best = win_duty[0];
      for (int i = 1; i < NL; i++)
         if (win_duty[i] > best) begin best = win_duty[i]; n = i; end
      m_sp = 0; m_bp = 0;
      if (!m_track) begin
         if (best != 0) begin m_valid = 1; m_dk = 0; m_track = 1; end
      end else if (best == 0) begin
         model_err(3);
         m_valid = 0;
         m_track = 0;
      end else begin
         delta = n - m_h;
         if (delta == 1 || delta == -1) begin
            down = (delta < 0);
            m_sp = 1;
            if (!m_dk) begin
               m_dir = down; m_dk = 1;
            end else if (down != m_dir) begin
               if ((m_h == NL-1 && !m_dir) || (m_h == 0 && m_dir)) begin
                  m_bp = 1;
                  if (m_sweep < 65535) m_sweep++;
               end else begin
                  model_err(2);
               end
               m_dir = down;
            end
         end else if (delta != 0) begin
            model_err(1);
            m_dk = 0;
         end
      end
      m_h = n;
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst  = 1'b1;
         leds = 8'($urandom);
         if (k == 0) begin
            model_reset();
            exp_q.push_back(snap(cyc + 1));
         end
      end
   endtask

   task automatic run_window();
      for (int i = 0; i < NL; i++) win_off[i] = $urandom_range(0, WIN-1);
      model_window();
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(snap(cyc + WIN));
      for (int k = 0; k < WIN; k++) begin
         if (k > 0) @(negedge clk);
         for (int i = 0; i < NL; i++)
            leds[i] = (((k + win_off[i]) % WIN) < win_duty[i]);
      end
   endtask

   task automatic partial_window(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst  = 1'b0;
         leds = 8'($urandom);
      end
   endtask

   task automatic set_dark();
      for (int i = 0; i < NL; i++) win_duty[i] = 0;
   endtask

   task automatic head_win(input int t);
      set_dark();
      win_duty[t] = WIN;
      run_window();
   endtask

   // random frame whose brightest LED is t (lower indices never tie it)
   task automatic rand_win(input int t);
      int v;
      set_dark();
      win_duty[t] = $urandom_range(64, WIN);
      for (int i = 0; i < NL; i++) begin
         if (i != t && $urandom_range(0, 1) == 1) begin
            v = $urandom_range(0, win_duty[t]);
            if (i < t && v == win_duty[t]) v--;
            win_duty[i] = v;
         end
      end
      run_window();
   endtask

   task automatic random_segment(input int nwin, input bit allow_err);
      int r, t;
      for (int w = 0; w < nwin; w++) begin
         r = $urandom_range(0, 99);
         if (!m_valid) t = $urandom_range(0, NL-1);
         else if (!m_dk) t = (m_h == 0) ? 1 : (m_h == NL-1) ? NL-2 : m_h + ($urandom_range(0, 1) ? 1 : -1);
         else begin
            t = m_dir ? m_h - 1 : m_h + 1;
            if (t < 0) t = 1;
            if (t > NL-1) t = NL-2;
         end
         if (r < 10) t = m_h;
         if (allow_err && r >= 75 && r < 85) t = $urandom_range(0, NL-1);
         if (allow_err && r >= 85 && r < 93 && m_valid) begin
            t = m_dir ? m_h + 1 : m_h - 1;
            if (t < 0 || t > NL-1) t = m_h;
         end
         if (allow_err && r >= 93) begin
            set_dark();
            run_window();
         end else begin
            rand_win(t);
         end
      end
   endtask

   initial begin
      model_reset();
      // 1: steady head at LED0
      do_reset(2);
      for (int w = 0; w < 3; w++) head_win(0);
      // 2: full sweep up and back down
      for (int p = 1; p < NL; p++) head_win(p);
      for (int p = NL-2; p >= 0; p--) head_win(p);
      // 3: duty-weighted head, then a tie resolved to the lower index
      do_reset(1);
      set_dark(); win_duty[3] = WIN; win_duty[2] = WIN/4; run_window();
      set_dark(); win_duty[4] = WIN/2; win_duty[5] = WIN/2; run_window();
      // 4: jump, then a dark window keeps the first error
      do_reset(1);
      head_win(2); head_win(3); head_win(6);
      set_dark(); run_window();
      // 5: reversal away from the ends
      do_reset(1);
      head_win(2); head_win(3); head_win(4); head_win(3);
      // 6: dark while tracking, reset mid-window, then head at LED7
      do_reset(1);
      head_win(5);
      set_dark(); run_window();
      partial_window(100);
      do_reset(2);
      head_win(7);
      // randomized sweeps
      for (int s = 0; s < 4; s++) begin
         do_reset($urandom_range(1, 3));
         random_segment(25, s[0]);
      end
      repeat (4) @(negedge clk);
      check("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
